btn_irq_ctrl: RTL and testbench

//   Debounced push-button interrupt source for the nanorv32 irq/eoi interface.

---
 rtl/btn_irq_ctrl.sv | 177 +++++++++++++++++
 tb/tb_btn_irq_ctrl.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/btn_irq_ctrl.sv
// Push-button interrupt source: 2-flop sync, optional debounce, edge -> pending -> irq.
// Define BTN_IRQ_CTRL_DEBOUNCE_EN to build the DEB_CYCLES debounce filter.
module btn_irq_ctrl #(
   parameter int N_SRC      = 4,
   parameter int IRQ_BASE   = 8,
   parameter int DEB_CYCLES = 50000
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             enable,
   input  logic             mem_valid,
   output logic             mem_ready,
   input  logic             mem_instr,
   input  logic [3:0]       mem_wstrb,
   input  logic [31:0]      mem_wdata,
   input  logic [31:0]      mem_addr,
   output logic [31:0]      mem_rdata,
   input  logic [N_SRC-1:0] btn_n,
   output logic [31:0]      irq,
   input  logic [31:0]      eoi
);

   localparam logic [1:0] REG_PENDING = 2'd0;
   localparam logic [1:0] REG_MASK    = 2'd1;
   localparam logic [1:0] REG_LEVEL   = 2'd2;
   localparam logic [1:0] REG_POL     = 2'd3;

   logic [N_SRC-1:0] sync1_q, sync1_d;
   logic [N_SRC-1:0] sync2_q, sync2_d;
   logic [N_SRC-1:0] s;
   logic [N_SRC-1:0] deb_q, deb_d;
   logic [N_SRC-1:0] deb_prev_q, deb_prev_d;
   logic [N_SRC-1:0] pending_q, pending_d;
   logic [N_SRC-1:0] mask_q, mask_d;
   logic [N_SRC-1:0] pol_q, pol_d;
   logic [31:0]      irq_q, irq_d;
   logic             mem_ready_q, mem_ready_d;
   logic [31:0]      mem_rdata_q, mem_rdata_d;

   logic [N_SRC-1:0] rise, fall, ev, clr;
   logic [N_SRC-1:0] eoi_src, wr_byte;
   logic             acc, wr_en;
   logic [1:0]       reg_sel;
   logic [31:0]      rd_val;

   // ---------------- synchroniser ----------------
   always_comb begin
      sync1_d = btn_n;
      sync2_d = sync1_q;
   end

   assign s = ~sync2_q;

   // ---------------- debounce ----------------
`ifdef BTN_IRQ_CTRL_DEBOUNCE_EN
   localparam int CNT_W = $clog2(DEB_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   for (genvar gi = 0; gi < N_SRC; gi++) begin : g_deb
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             deb_bit_d;

      // Counter stops at CNT_LAST and restarts, so it can never wrap.
      always_comb begin
         cnt_d     = cnt_q;
         deb_bit_d = deb_q[gi];
         if (s[gi] == deb_q[gi]) begin
            cnt_d = '0;
         end else if (cnt_q == CNT_LAST) begin
            deb_bit_d = s[gi];
            cnt_d     = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk or negedge resetn) begin
         if (!resetn) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end

      assign deb_d[gi] = deb_bit_d;
   end
`else
   assign deb_d = s;
`endif

   // ---------------- edge detect ----------------
   always_comb begin
      deb_prev_d = deb_q;
      rise       = deb_q & ~deb_prev_q;
      fall       = ~deb_q & deb_prev_q;
      ev         = (rise & ~pol_q) | (fall & pol_q);
   end

   // ---------------- bus decode ----------------
   assign acc     = enable & mem_valid & ~mem_ready_q;
   assign wr_en   = acc & mem_wstrb[0];
   assign reg_sel = mem_addr[3:2];
   assign wr_byte = mem_wdata[N_SRC-1:0];
   assign eoi_src = eoi[IRQ_BASE +: N_SRC];

   always_comb begin
      rd_val = '0;
      case (reg_sel)
         REG_PENDING: rd_val[N_SRC-1:0] = pending_q;
         REG_MASK:    rd_val[N_SRC-1:0] = mask_q;
         REG_LEVEL:   rd_val[N_SRC-1:0] = deb_q;
         REG_POL:     rd_val[N_SRC-1:0] = pol_q;
         default:     rd_val = '0;
      endcase
      mem_ready_d = acc;
      mem_rdata_d = acc ? rd_val : '0;
   end

   // ---------------- pending / mask / pol / irq ----------------
   always_comb begin
      clr = eoi_src;
      if (wr_en && (reg_sel == REG_PENDING)) begin
         clr = clr | wr_byte;
      end
      // A new event in the same cycle as a clear keeps the bit set.
      pending_d = (pending_q & ~clr) | ev;

      mask_d = mask_q;
      if (wr_en && (reg_sel == REG_MASK)) begin
         mask_d = wr_byte;
      end

      pol_d = pol_q;
      if (wr_en && (reg_sel == REG_POL)) begin
         pol_d = wr_byte;
      end

      irq_d = '0;
      irq_d[IRQ_BASE +: N_SRC] = pending_q & mask_q;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sync1_q     <= '1;
         sync2_q     <= '1;
         deb_q       <= '0;
         deb_prev_q  <= '0;
         pending_q   <= '0;
         mask_q      <= '0;
         pol_q       <= '0;
         irq_q       <= '0;
         mem_ready_q <= 1'b0;
         mem_rdata_q <= '0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         deb_q       <= deb_d;
         deb_prev_q  <= deb_prev_d;
         pending_q   <= pending_d;
         mask_q      <= mask_d;
         pol_q       <= pol_d;
         irq_q       <= irq_d;
         mem_ready_q <= mem_ready_d;
         mem_rdata_q <= mem_rdata_d;
      end
   end

   assign irq       = irq_q;
   assign mem_ready = mem_ready_q;
   assign mem_rdata = mem_rdata_q;

   // Fetch flag, upper byte lanes and out-of-range address/eoi bits have no effect.
   logic unused_inputs;
   assign unused_inputs = ^{mem_instr, mem_wstrb[3:1], mem_wdata, mem_addr[31:4],
                            mem_addr[1:0], eoi, (DEB_CYCLES > 1)};

endmodule

// File: tb/tb_btn_irq_ctrl.sv
// Self-checking bench for btn_irq_ctrl: per-cycle reference model plus directed literal checks.
// Latencies follow BTN_IRQ_CTRL_DEBOUNCE_EN when the bench is built with the same define.
module tb_btn_irq_ctrl;

   localparam int N    = 4;
   localparam int BASE = 8;
   localparam int DEB  = 8;
`ifdef BTN_IRQ_CTRL_DEBOUNCE_EN
   localparam int DEB_EFF = DEB;
   localparam int DLAT    = 10;   // input edge -> debounced edge: 2 sync + 8 stable
   localparam int LAT     = 12;   // input edge -> irq high
`else
   localparam int DEB_EFF = 1;
   localparam int DLAT    = 3;
   localparam int LAT     = 5;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        enable, mem_valid, mem_ready, mem_instr;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_wdata, mem_addr, mem_rdata;
   logic [N-1:0] btn_n;
   logic [31:0] irq, eoi;

   btn_irq_ctrl #(.N_SRC(N), .IRQ_BASE(BASE), .DEB_CYCLES(DEB)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .enable    (enable),
      .mem_valid (mem_valid),
      .mem_ready (mem_ready),
      .mem_instr (mem_instr),
      .mem_wstrb (mem_wstrb),
      .mem_wdata (mem_wdata),
      .mem_addr  (mem_addr),
      .mem_rdata (mem_rdata),
      .btn_n     (btn_n),
      .irq       (irq),
      .eoi       (eoi)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [N-1:0] m_pending, m_mask, m_pol, m_deb, m_rose, m_fell;
   logic [31:0]  m_irq, m_rdata;
   logic         m_ready;
   int           m_run [N];
   logic [N-1:0] m_dly [$];   // raw button samples still inside the 2-cycle synchroniser

   task automatic model_reset();
      m_pending = '0; m_mask = '0; m_pol = '0; m_deb = '0;
      m_rose = '0; m_fell = '0;
      m_irq = '0; m_rdata = '0; m_ready = 1'b0;
      for (int i = 0; i < N; i++) m_run[i] = 0;
      m_dly.delete();
      m_dly.push_back('1);
      m_dly.push_back('1);
   endtask

   task automatic model_step();
      logic [N-1:0] ev, clr, s, wdat;
      logic         acc, wr;
      logic [1:0]   sel;
      logic [31:0]  rval;
      ev   = (m_rose & ~m_pol) | (m_fell & m_pol);
      acc  = enable && mem_valid && !m_ready;
      wr   = acc && mem_wstrb[0];
      sel  = mem_addr[3:2];
      wdat = mem_wdata[N-1:0];
      case (sel)
         2'd0:    rval = {28'b0, m_pending};
         2'd1:    rval = {28'b0, m_mask};
         2'd2:    rval = {28'b0, m_deb};
         default: rval = {28'b0, m_pol};
      endcase
      m_rdata = acc ? rval : 32'b0;
      m_ready = acc;
      m_irq   = 32'(m_pending & m_mask) << BASE;
      clr = eoi[BASE +: N];
      if (wr && sel == 2'd0) clr = clr | wdat;
      m_pending = (m_pending & ~clr) | ev;
      if (wr && sel == 2'd1) m_mask = wdat;
      if (wr && sel == 2'd3) m_pol = wdat;
      // a new level is accepted once it has differed from the old one DEB_EFF cycles in a row
      s = ~m_dly.pop_front();
      m_dly.push_back(btn_n);
      m_rose = '0;
      m_fell = '0;
      for (int i = 0; i < N; i++) begin
         if (s[i] == m_deb[i]) begin
            m_run[i] = 0;
         end else begin
            m_run[i]++;
            if (m_run[i] == DEB_EFF) begin
               m_run[i] = 0;
               m_deb[i] = s[i];
               if (s[i]) m_rose[i] = 1'b1;
               else      m_fell[i] = 1'b1;
            end
         end
      end
   endtask

   initial begin
      model_reset();
      forever begin
         @(posedge clk or negedge resetn);
         if (!resetn) model_reset();
         else         model_step();
      end
   end

   // ---------------- per-cycle compare ----------------
   initial begin
      forever begin
         @(negedge clk);
         chk("irq", irq, m_irq);
         chk("mem_ready", {31'b0, mem_ready}, {31'b0, m_ready});
         chk("mem_rdata", mem_rdata, m_rdata);
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic bus(input logic [1:0] r, input logic [3:0] strb, input logic [31:0] wd,
                      output logic [31:0] rd);
      enable    = 1'b1;
      mem_valid = 1'b1;
      mem_addr  = 32'h4000_0000 | {28'b0, r, 2'b00};
      mem_wstrb = strb;
      mem_wdata = wd;
      tick();
      chk("ready_pulse", {31'b0, mem_ready}, 32'd1);
      rd        = mem_rdata;
      enable    = 1'b0;
      mem_valid = 1'b0;
      mem_wstrb = 4'b0;
      mem_wdata = 32'b0;
      tick();
      $display("bus %s reg=%0d wstrb=%b wdata=0x%08h rdata=0x%08h",
               (strb != 4'b0) ? "wr" : "rd", r, strb, wd, rd);
   endtask

   task automatic rd_reg(input logic [1:0] r, output logic [31:0] v);
      bus(r, 4'b0000, 32'b0, v);
   endtask

   task automatic wr_reg(input logic [1:0] r, input logic [31:0] v);
      logic [31:0] dummy;
      bus(r, 4'b0001, v, dummy);
   endtask

   task automatic wait_irq(input int b, output int lat);
      lat = -1;
      for (int k = 1; k <= 40 && lat < 0; k++) begin
         tick();
         if (irq[b]) lat = k;
      end
   endtask

   // ---------------- directed sequence ----------------
   logic [31:0] v;
   int lat, hits;

   initial begin
      resetn = 1'b1; enable = 1'b0; mem_valid = 1'b0; mem_instr = 1'b0;
      mem_wstrb = 4'b0; mem_wdata = 32'b0; mem_addr = 32'b0;
      btn_n = '1; eoi = 32'b0;
      #1 resetn = 1'b0;
      repeat (3) @(posedge clk);
      #1 resetn = 1'b1;

      for (int r = 0; r < 4; r++) begin
         rd_reg(2'(r), v);
         chk("reset_read", v, 32'h0);
      end

      // press source 1 with it unmasked
      wr_reg(2'd1, 32'h2);
      btn_n[1] = 1'b0;
      wait_irq(BASE + 1, lat);
      chk("press_latency", 32'(lat), 32'(LAT));
      rd_reg(2'd0, v); chk("pending_after_press", v, 32'h2);
      rd_reg(2'd2, v); chk("level_after_press", v, 32'h2);

      // bouncing source 0
      wr_reg(2'd1, 32'h3);
      hits = 0;
      for (int j = 0; j < 8; j++) begin
         btn_n[0] = (j % 2 == 0) ? 1'b0 : 1'b1;
         for (int c = 0; c < 5; c++) begin
            tick();
            if (irq[BASE]) hits++;
         end
      end
`ifdef BTN_IRQ_CTRL_DEBOUNCE_EN
      chk("bounce_quiet", 32'(hits), 32'd0);
      rd_reg(2'd0, v); chk("pending_after_bounce", v, 32'h2);
`else
      rd_reg(2'd0, v); chk("pending_after_bounce", v, 32'h3);
`endif
      eoi[BASE] = 1'b1; tick(); eoi[BASE] = 1'b0;
      tick(); tick();
      btn_n[0] = 1'b0;
      wait_irq(BASE, lat);
      chk("settle_latency", 32'(lat), 32'(LAT));
      rd_reg(2'd0, v); chk("pending_after_settle", v, 32'h3);

      // eoi clears, and loses against a simultaneous event
      eoi[BASE + 1] = 1'b1; tick();
      chk("irq9_hold", {31'b0, irq[BASE + 1]}, 32'd1);
      eoi[BASE + 1] = 1'b0; tick();
      chk("eoi_clear", {31'b0, irq[BASE + 1]}, 32'd0);
      wr_reg(2'd3, 32'h2);
      btn_n[1] = 1'b1;
      repeat (DLAT) tick();
      eoi[BASE + 1] = 1'b1; tick(); eoi[BASE + 1] = 1'b0;
      tick();
      chk("eoi_vs_edge", {31'b0, irq[BASE + 1]}, 32'd1);
      rd_reg(2'd0, v); chk("pending_set_wins", v, 32'h3);

      // W1C on PENDING, and the ignored byte lane
      btn_n = 4'b0010;
      repeat (LAT + 1) tick();
      rd_reg(2'd0, v); chk("pending_all", v, 32'hF);
      wr_reg(2'd0, 32'h5);
      rd_reg(2'd0, v); chk("w1c", v, 32'hA);
      bus(2'd0, 4'b0010, 32'hFF, v);
      rd_reg(2'd0, v); chk("lane1_ignored", v, 32'hA);

      // release polarity on source 3
      btn_n = 4'b1010;
      repeat (LAT + 1) tick();
      wr_reg(2'd3, 32'h8);
      wr_reg(2'd1, 32'h8);
      wr_reg(2'd0, 32'hF);
      btn_n = 4'b0010;
      hits = 0;
      for (int c = 0; c < LAT + 4; c++) begin
         tick();
         if (irq[BASE + 3]) hits++;
      end
      chk("pol_no_press_irq", 32'(hits), 32'd0);
      btn_n = 4'b1010;
      wait_irq(BASE + 3, lat);
      chk("release_latency", 32'(lat), 32'(LAT));
      rd_reg(2'd2, v); chk("level_mix", v, 32'h5);

      // reset in the middle of an access and of a debounce
      btn_n = 4'b1111;
      repeat (3) tick();
      enable = 1'b1; mem_valid = 1'b1; mem_addr = 32'h0; mem_wstrb = 4'b0;
      tick();
      #1 resetn = 1'b0;
      #1;
      chk("reset_irq", irq, 32'h0);
      chk("reset_ready", {31'b0, mem_ready}, 32'd0);
      enable = 1'b0; mem_valid = 1'b0;
      tick(); tick();
      resetn = 1'b1;
      for (int r = 0; r < 4; r++) begin
         rd_reg(2'(r), v);
         chk("post_reset_read", v, 32'h0);
      end

      repeat (2) tick();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
